// File: rtl/mult_product_accumulator_if.sv
// Handshake bundle between the multiplier side, the product accumulator and its result consumer.
// The ovf signal exists only when MULT_ACC_OVF_FLAG_EN is defined.
interface mult_product_accumulator_if #(
    parameter int unsigned PROD_W = 128,
    parameter int unsigned ACC_W  = 144,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic              busy;
`ifdef MULT_ACC_OVF_FLAG_EN
    logic              ovf;
`endif

    modport slave (
        input  start, len, prod_in, prod_valid, acc_ready,
`ifdef MULT_ACC_OVF_FLAG_EN
        output ovf,
`endif
        output prod_ready, acc_out, acc_valid, busy
    );

    modport master (
        output start, len, prod_in, prod_valid, acc_ready,
`ifdef MULT_ACC_OVF_FLAG_EN
        input  ovf,
`endif
        input  prod_ready, acc_out, acc_valid, busy
    );
endinterface

// File: rtl/mult_product_accumulator.sv
// Sums a programmed count of multiplier products into a wide accumulator and hands the sum downstream.
// Optional sticky carry-out flag (ovf) enabled by defining MULT_ACC_OVF_FLAG_EN.
module mult_product_accumulator #(
    parameter int unsigned PROD_W = 128,
    parameter int unsigned ACC_W  = 144,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    mult_product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_remaining;
    logic              w_prod_ready;
    logic              w_acc_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_job_start;
`ifdef MULT_ACC_OVF_FLAG_EN
    logic [ACC_W:0]    w_sum;
    logic              r_ovf;
`else
    logic [ACC_W-1:0]  w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_prod_ready = 1'b0;
        w_acc_valid  = 1'b0;
        w_busy       = 1'b0;
        w_job_start  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_job_start = 1'b1;
                    w_next      = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_prod_ready = 1'b1;
                w_busy       = 1'b1;
                w_accept     = bus.prod_valid;
                if (bus.prod_valid && (r_remaining == CNT_W'(1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_acc_valid = 1'b1;
                w_busy      = 1'b1;
                if (bus.acc_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef MULT_ACC_OVF_FLAG_EN
    // One extra bit keeps the carry out of the accumulator for the sticky flag.
    always_comb w_sum = {1'b0, r_acc} + (ACC_W+1)'(bus.prod_in);
`else
    always_comb w_sum = r_acc + ACC_W'(bus.prod_in);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_remaining <= '0;
        end else if (w_job_start) begin
            r_acc       <= '0;
            r_remaining <= bus.len;
        end else if (w_accept) begin
            r_acc       <= w_sum[ACC_W-1:0];
            r_remaining <= r_remaining - 1'b1;
        end
    end

`ifdef MULT_ACC_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_job_start) begin
            r_ovf <= 1'b0;
        end else if (w_accept && w_sum[ACC_W]) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.prod_ready = w_prod_ready;
    assign bus.acc_valid  = w_acc_valid;
    assign bus.busy       = w_busy;
    assign bus.acc_out    = r_acc;
endmodule
